// File: rtl/painel_pkg.sv
// Shared types and sizing helpers for the LED matrix scan driver.
package painel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    DRIVE
  } state_t;

  localparam int DEF_COLS = 5;
  localparam int DEF_ROWS = 7;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Loadable down-counter timing one GAP or DRIVE slot; last is high on the
// final cycle of the slot.
module scan_slot_timer #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  // NOTE: registers are written with non-blocking assignments so every
  // flop samples the values that existed before the clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/matrix_scan_driver.sv
// Double-buffered column-multiplexed LED matrix driver with dead-time gaps.
// Optional brightness PWM on the row outputs: define MATRIX_SCAN_BRIGHTNESS_PWM_EN.
module matrix_scan_driver
  import painel_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int DIV     = 2000,
  parameter int GAP_CYC = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [COLS*ROWS-1:0] frame_in,
  input  logic                 load,
  input  logic                 enable,
`ifdef MATRIX_SCAN_BRIGHTNESS_PWM_EN
  input  logic [2:0]           brightness,
`endif
  output logic [COLS-1:0]      col_sel,
  output logic [ROWS-1:0]      row_out,
  output logic                 frame_start,
  output logic                 load_ack
);

  localparam int              TW       = width_of(max3(DIV, GAP_CYC, 1));
  localparam int              CW       = width_of(COLS);
  localparam logic [CW-1:0]   LAST_COL = CW'(COLS - 1);
  localparam logic [TW-1:0]   DIV_LD   = TW'(DIV - 1);
  localparam logic [TW-1:0]   GAP_LD   = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [COLS-1:0] COL0_SEL = COLS'(1);
  // Every slot opens with a gap unless the gap is configured away.
  localparam state_t          SLOT_ST  = (GAP_CYC > 0) ? GAP : DRIVE;
  localparam logic [TW-1:0]   SLOT_LD  = (GAP_CYC > 0) ? GAP_LD : DIV_LD;

  state_t                 state, state_n;
  logic [CW-1:0]          col, col_n;
  logic [COLS*ROWS-1:0]   staging, shadow, shadow_n;
  logic                   pending;
  logic                   tmr_clear, tmr_load, tmr_last;
  logic [TW-1:0]          tmr_val;
  logic                   boundary, commit, entering_drive, row_gate;
  logic [ROWS-1:0]        row_data;

  scan_slot_timer #(.W(TW)) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    state_n   = state;
    col_n     = col;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = DIV_LD;
    if (!enable) begin
      state_n   = IDLE;
      col_n     = '0;
      tmr_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_n  = SLOT_ST;
          col_n    = '0;
          tmr_load = 1'b1;
          tmr_val  = SLOT_LD;
        end
        GAP: begin
          if (tmr_last) begin
            state_n  = DRIVE;
            tmr_load = 1'b1;
            tmr_val  = DIV_LD;
          end
        end
        DRIVE: begin
          if (tmr_last) begin
            state_n  = SLOT_ST;
            col_n    = (col == LAST_COL) ? '0 : col + 1'b1;
            tmr_load = 1'b1;
            tmr_val  = SLOT_LD;
          end
        end
        default: begin
          state_n   = IDLE;
          col_n     = '0;
          tmr_clear = 1'b1;
        end
      endcase
    end

    // New frames reach the shadow only while idle or between frames.
    boundary = enable && (state == DRIVE) && tmr_last && (col == LAST_COL);
    commit   = ((state == IDLE) && pending) || (boundary && (pending || load));
    shadow_n = shadow;
    if (commit) shadow_n = load ? frame_in : staging;

    entering_drive = (state_n == DRIVE) && ((state != DRIVE) || tmr_last);
    row_data       = shadow_n[col_n*ROWS +: ROWS];
  end

`ifdef MATRIX_SCAN_BRIGHTNESS_PWM_EN
  logic [2:0] pwm, pwm_n;

  assign pwm_n    = entering_drive ? 3'd0 : pwm + 3'd1;
  assign row_gate = (pwm_n <= brightness);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pwm <= 3'd0;
    else        pwm <= (state_n == DRIVE) ? pwm_n : 3'd0;
  end
`else
  assign row_gate = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the frame buffers are ordinary flops, not a RAM, so they are
      // reset like the rest of the state and a fresh board shows a dark frame.
      state       <= IDLE;
      col         <= '0;
      staging     <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      col_sel     <= '0;
      row_out     <= '0;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      shadow   <= shadow_n;
      load_ack <= commit;
      if (load) staging <= frame_in;
      if (commit)    pending <= 1'b0;
      else if (load) pending <= 1'b1;
      // Outputs follow the state being entered, so they line up with it.
      col_sel     <= (state_n == DRIVE) ? (COL0_SEL << col_n) : '0;
      row_out     <= ((state_n == DRIVE) && row_gate) ? row_data : '0;
      frame_start <= entering_drive && (col_n == '0);
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver: idle, loads, frame-boundary commit,
// enable drop, async reset, and brightness PWM when that build option is on.
module tb_matrix_scan_driver;

  localparam int COLS = 5;
  localparam int ROWS = 7;
  localparam int GAP  = 1;
`ifdef MATRIX_SCAN_BRIGHTNESS_PWM_EN
  localparam int DIV  = 8;
`else
  localparam int DIV  = 4;
`endif
  localparam int P     = DIV + GAP;
  localparam int FRAME = COLS * P;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic [COLS*ROWS-1:0] frame_in = '0;
  logic                 load = 1'b0;
  logic                 enable = 1'b0;
`ifdef MATRIX_SCAN_BRIGHTNESS_PWM_EN
  logic [2:0]           brightness = 3'd7;
`endif
  logic [COLS-1:0]      col_sel;
  logic [ROWS-1:0]      row_out;
  logic                 frame_start;
  logic                 load_ack;

  matrix_scan_driver #(
    .COLS(COLS), .ROWS(ROWS), .DIV(DIV), .GAP_CYC(GAP)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .frame_in    (frame_in),
    .load        (load),
    .enable      (enable),
`ifdef MATRIX_SCAN_BRIGHTNESS_PWM_EN
    .brightness  (brightness),
`endif
    .col_sel     (col_sel),
    .row_out     (row_out),
    .frame_start (frame_start),
    .load_ack    (load_ack)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int k;
  int ack_cnt, last_ack_k, col_cyc, row_cyc;
  logic [COLS*ROWS-1:0] m_shadow = '0;
  logic [COLS*ROWS-1:0] m_staging = '0;
  logic                 m_pending = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One scan cycle: advance the model across the edge, then compare outputs.
  task automatic tick();
    logic            exp_ack;
    logic [COLS-1:0] e_col;
    logic [ROWS-1:0] e_row;
    logic            e_fs;
    int              pos, c;
    exp_ack = 1'b0;
    if (k > 0 && (k % FRAME) == 0 && (m_pending || load)) begin
      m_shadow  = load ? frame_in : m_staging;
      m_pending = 1'b0;
      exp_ack   = 1'b1;
    end else if (load) begin
      m_pending = 1'b1;
    end
    if (load) m_staging = frame_in;
    step();
    pos   = k % P;
    c     = (k / P) % COLS;
    e_col = '0;
    e_row = '0;
    e_fs  = 1'b0;
    if (pos >= GAP) begin
      e_col[c] = 1'b1;
      e_row    = m_shadow[c*ROWS +: ROWS];
      e_fs     = (c == 0) && (pos == GAP);
`ifdef MATRIX_SCAN_BRIGHTNESS_PWM_EN
      if (((pos - GAP) % 8) > int'(brightness)) e_row = '0;
`endif
    end
    check($sformatf("scan k=%0d {fs,col,row}", k), {frame_start, col_sel, row_out}, {e_fs, e_col, e_row});
    check($sformatf("ack k=%0d", k), load_ack, exp_ack);
    if (load_ack) begin
      ack_cnt++;
      last_ack_k = k;
    end
    if (col_sel != '0) col_cyc++;
    if (row_out != '0) row_cyc++;
    k++;
  endtask

  task automatic run_to(input int kk);
    while (k < kk) tick();
  endtask

  initial begin
    logic [COLS-1:0] or_col;
    logic [ROWS-1:0] or_row;
    logic            or_fs, or_ack;
    k = 0; ack_cnt = 0; last_ack_k = -1; col_cyc = 0; row_cyc = 0;

    // 1. Reset, then a quiet idle stretch.
    repeat (3) step();
    check("rst col_sel", col_sel, '0);
    check("rst row_out", row_out, '0);
    RST_N = 1'b1;
    or_col = '0; or_row = '0; or_fs = 1'b0; or_ack = 1'b0;
    repeat (50) begin
      step();
      or_col |= col_sel;
      or_row |= row_out;
      or_fs  |= frame_start;
      or_ack |= load_ack;
    end
    check("idle col_sel", or_col, '0);
    check("idle row_out", or_row, '0);
    check("idle frame_start", or_fs, 1'b0);
    check("idle load_ack", or_ack, 1'b0);

    // 2. Load while idle, then scan a full-on frame.
    frame_in = 35'h7_FFFF_FFFF;
    load = 1'b1;
    step();
    load = 1'b0;
    check("idle load ack early", load_ack, 1'b0);
    step();
    check("idle load ack", load_ack, 1'b1);
    step();
    check("idle load ack pulse", load_ack, 1'b0);
    m_shadow = 35'h7_FFFF_FFFF;
    m_staging = 35'h7_FFFF_FFFF;
    enable = 1'b1;
    run_to(FRAME);
    check("frame drive cycles", col_cyc, COLS * DIV);
    check("frame row cycles", row_cyc, COLS * DIV);

    // 3. Load during column 2: committed only at the frame boundary.
    run_to(FRAME + 2*P + GAP + 1);
    frame_in = {7'h04, 7'h03, 7'h02, 7'h01, 7'h55};
    ack_cnt = 0;
    load = 1'b1;
    tick();
    load = 1'b0;
    run_to(2*FRAME + P);
    check("midscan ack count", ack_cnt, 1);
    check("midscan ack cycle", last_ack_k, 2*FRAME);

    // 4. Second load lands exactly on the commit cycle; newest wins.
    ack_cnt = 0;
    run_to(2*FRAME + 2*P + GAP + 1);
    frame_in = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h11};
    load = 1'b1;
    tick();
    load = 1'b0;
    run_to(3*FRAME);
    frame_in = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h2A};
    load = 1'b1;
    tick();
    load = 1'b0;
    run_to(3*FRAME + GAP + 1);
    check("bypass col0 row_out", row_out, 7'h2A);
    run_to(4*FRAME + P);
    check("bypass ack count", ack_cnt, 1);
    check("bypass ack cycle", last_ack_k, 3*FRAME);

    // 5. Drop enable in column 3, then restart from column 0.
    run_to(4*FRAME + 3*P + GAP + 2);
    enable = 1'b0;
    step();
    check("drop col_sel", col_sel, '0);
    check("drop row_out", row_out, '0);
    check("drop frame_start", frame_start, 1'b0);
    or_col = '0; or_ack = 1'b0;
    repeat (4) begin
      step();
      or_col |= col_sel;
      or_ack |= load_ack;
    end
    check("disabled col_sel", or_col, '0);
    check("disabled load_ack", or_ack, 1'b0);
    enable = 1'b1;
    k = 0;
    run_to(GAP + 1);
    check("restart col_sel", col_sel, 5'b00001);
    check("restart frame_start", frame_start, 1'b1);
    run_to(FRAME);

`ifdef MATRIX_SCAN_BRIGHTNESS_PWM_EN
    // 6. Brightness 3 lights rows for 4 of every 8 drive cycles.
    brightness = 3'd3;
    col_cyc = 0;
    row_cyc = 0;
    run_to(2*FRAME);
    check("pwm col_sel cycles", col_cyc, COLS * 8);
    check("pwm row cycles", row_cyc, COLS * 4);
`endif

    // 7. Asynchronous reset mid-drive clears outputs without a clock edge.
    run_to(k + GAP + 2);
    check("pre-reset col_sel", col_sel, 5'b00001);
    #2;
    RST_N = 1'b0;
    #1;
    check("async rst col_sel", col_sel, '0);
    check("async rst row_out", row_out, '0);
    step();
    RST_N = 1'b1;
    step();
    check("post rst load_ack", load_ack, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan_driver.md
Name: matrix_scan_driver

Overview:
- Downstream consumer of the display shift-register chain: takes the parallel snapshot of all register-cell Q outputs (one bit per LED) and multiplexes it onto a COLS x ROWS LED matrix, one column at a time.
- Double-buffered, so frames shifted or loaded mid-scan never tear.
- A dead-time gap between column slots suppresses ghosting.
- Sits between the register chain and the board's column/row drivers.

Parameters:
- COLS, 5, number of matrix columns (>=2).
- ROWS, 7, number of matrix rows (>=1).
- DIV, 2000, CLK cycles each column is driven (>=1).
- GAP_CYC, 16, blank cycles between column slots (>=0; 0 = no gap).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- frame_in  in  COLS*ROWS  register-chain snapshot; bit c*ROWS+r = column c (0 = leftmost), row r (0 = top).
- load  in  1  single-cycle request to capture frame_in.
- enable  in  1  scan enable; 0 blanks the matrix.
- col_sel  out  COLS  one-hot column drive, active high.
- row_out  out  ROWS  row data for the driven column, active high.
- frame_start  out  1  one-cycle pulse on the first DRIVE cycle of column 0.
- load_ack  out  1  one-cycle pulse when a frame is committed to the shadow buffer.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset values: col_sel=0, row_out=0, frame_start=0, load_ack=0, staging=0, shadow=0, pending=0, col=0, slot counter=0, state IDLE.
- Storage: staging register, shadow register and pending flag.
  - load=1 copies frame_in to staging and sets pending.
  - Back-to-back loads: last one wins.
- Commit (staging -> shadow, pending cleared, load_ack=1 for one cycle) happens only:
  - in IDLE, on the cycle after pending is set; or
  - on the cycle the FSM moves from column COLS-1 into the slot for column 0 (frame boundary).
- Commit on a cycle with load=1: frame_in bypasses straight to shadow (newest data wins), pending ends cleared, load_ack=1.
- FSM states: IDLE, GAP, DRIVE.
  - IDLE: outputs 0. enable=1 -> GAP with col=0 (or DRIVE if GAP_CYC=0).
  - GAP: col_sel=0, row_out=0 for exactly GAP_CYC cycles, then DRIVE.
  - DRIVE: for exactly DIV cycles, col_sel=1<<col and row_out=shadow[col*ROWS +: ROWS]. On the last cycle, col <= (col==COLS-1) ? 0 : col+1, then next state GAP (or DRIVE if GAP_CYC=0).
- Outputs are registered, so they change on the cycle after a state or slot change.
- Full frame period = COLS*(DIV+GAP_CYC) cycles.
- frame_start: asserted together with the first non-zero col_sel for column 0.
- enable falls mid-scan:
  - next cycle outputs 0, state IDLE, col=0, counters cleared;
  - shadow, staging and pending are retained;
  - re-enabling restarts at column 0.
- Slot counter width: clog2(max(DIV,GAP_CYC,1)). Column index width: clog2(COLS). col never exceeds COLS-1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously).

Optional Feature:
- Macro: MATRIX_SCAN_BRIGHTNESS_PWM_EN.
- Defined:
  - adds input brightness[2:0];
  - a 3-bit pwm counter resets to 0 at DRIVE entry and increments every DRIVE cycle, wrapping;
  - row_out is the column data only while pwm <= brightness, otherwise 0;
  - col_sel is unaffected;
  - brightness=7 gives full-on.
- Undefined: no brightness port; row_out is full-on throughout DRIVE.

Decomposition:
- Shared package painel_pkg holds:
  - state enum {IDLE, GAP, DRIVE};
  - default COLS/ROWS constants;
  - clog2-based width helper.
- One natural sub-module, scan_slot_timer: loadable down-counter that asserts a last-cycle flag. Instantiated once and reloaded with DIV or GAP_CYC on each state change.

Test Plan:
Bench parameters: COLS=5, ROWS=7, DIV=4, GAP_CYC=1.
1. Reset/idle: RST_N low, then high with enable=0 for 50 cycles -> col_sel, row_out, frame_start and load_ack all stay 0.
2. Load in IDLE: frame_in=35'h7_FFFF_FFFF, one-cycle load -> load_ack next cycle. Then enable=1 -> columns 0..4 each driven for exactly 4 cycles with row_out=7'h7F, separated by 1 blank cycle. frame_start pulses every 25 cycles.
3. Mid-scan load: during column 2, load a pattern with column 0 = 7'h55 -> load_ack only at the column 4 -> 0 boundary. The column 3 and 4 slots still show the old data; column 0 then shows 7'h55.
4. Simultaneous: load asserted exactly on the commit cycle with frame_in column 0 = 7'h2A -> column 0 shows 7'h2A, pending=0, and no second load_ack.
5. enable drop during column 3 DRIVE -> outputs 0 next cycle. Re-enable -> first DRIVE is column 0, with frame_start.
6. PWM (macro defined), brightness=3, DIV=8 -> row_out active exactly 4 of every 8 DRIVE cycles, while col_sel stays high for all 8.
